fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 tb/tb_fifo_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: reads 32-bit words from a FIFO and sends each one as 8N1 UART bytes, LSB byte first, optionally preceded by a header byte.
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_enable                 permits new words to start
//   i_fifo_empty, i_fifo_q   FIFO status and read data (data valid the cycle after a request)
//   o_fifo_rdreq             single-cycle FIFO read request
//   o_tx                     registered UART line, idle high
//   o_busy, o_word_done      word in progress, one-cycle end-of-word pulse
module fifo_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter bit         HEADER_EN    = 1'b1,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rdreq,
  input  logic [31:0] i_fifo_q,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_word_done
);
  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BYTE = HEADER_EN ? 3'd4 : 3'd3;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    r_byte_cnt;
  logic [31:0]   r_word;
  logic [7:0]    r_byte;
  logic          r_tx;
  logic          r_word_done;
  logic          w_bit_end;
  logic [1:0]    w_sel;
  assign w_bit_end = r_clk_cnt == LAST_CLK;
  // Word byte that follows byte r_byte_cnt; without a header byte 0 is sent straight from FETCH.
  assign w_sel = HEADER_EN ? r_byte_cnt[1:0] : r_byte_cnt[1:0] + 2'd1;
  // The request is issued in the IDLE cycle itself so the FIFO data lands during FETCH.
  assign o_fifo_rdreq = !i_rst && r_state == IDLE && i_enable && !i_fifo_empty;
  assign o_busy = o_fifo_rdreq || r_state != IDLE;
  assign o_tx = r_tx;
  assign o_word_done = r_word_done;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_byte      <= '0;
      r_tx        <= 1'b1;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        IDLE: if (o_fifo_rdreq) r_state <= FETCH;
        FETCH: begin
          r_word     <= i_fifo_q;
          r_byte     <= HEADER_EN ? HEADER_BYTE : i_fifo_q[7:0];
          r_byte_cnt <= '0;
          r_clk_cnt  <= '0;
          r_tx       <= 1'b0;
          r_state    <= START;
        end
        START:
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_byte[0];
            r_byte    <= r_byte >> 1;
            r_state   <= DATA;
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        DATA:
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx      <= r_byte[0];
              r_byte    <= r_byte >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        STOP:
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_byte_cnt == LAST_BYTE) begin
              r_byte_cnt  <= '0;
              r_word_done <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
              r_byte     <= 8'(r_word >> {w_sel, 3'b000});
              r_tx       <= 1'b0;
              r_state    <= START;
            end
          end else r_clk_cnt <= r_clk_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx with and without header, using a FIFO model and a UART receiver model.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  int push_a = 0, pop_a = 0, push_b = 0, pop_b = 0;
  logic [31:0] q_a = '0, q_b = '0;
  logic empty_a, empty_b, rdreq_a, rdreq_b, tx_a, tx_b, busy_a, busy_b, wd_a, wd_b;
  assign empty_a = push_a == pop_a;
  assign empty_b = push_b == pop_b;
  fifo_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty_a), .o_fifo_rdreq(rdreq_a),
    .i_fifo_q(q_a), .o_tx(tx_a), .o_busy(busy_a), .o_word_done(wd_a));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty_b), .o_fifo_rdreq(rdreq_b),
    .i_fifo_q(q_b), .o_tx(tx_b), .o_busy(busy_b), .o_word_done(wd_b));
  always @(posedge clk) begin
    if (rdreq_a && !empty_a) begin
      q_a   <= mem_a[pop_a];
      pop_a <= pop_a + 1;
    end
    if (rdreq_b && !empty_b) begin
      q_b   <= mem_b[pop_b];
      pop_b <= pop_b + 1;
    end
  end
  int rdc_a = 0, wdc_a = 0, wdn_a = 0, wdn_b = 0, co_b = 0, bad_idle = 0;
  logic watch = 1'b0;
  always @(negedge clk) begin
    if (rdreq_a) rdc_a = cyc;
    if (wd_a) begin
      wdn_a++;
      wdc_a = cyc;
    end
    if (wd_b) wdn_b++;
    if (rdreq_b && wd_b) co_b++;
    if (watch && (tx_a !== 1'b1 || busy_a !== 1'b0 || rdreq_a !== 1'b0)) bad_idle++;
  end
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic txs(input bit s);
    return s ? tx_b : tx_a;
  endfunction
  // Receives one byte: start bit, 8 data bits and stop bit sampled mid-bit, checked as one 10-bit frame.
  task automatic rx(input bit s, input logic [7:0] e, input string tag, output int t);
    logic [9:0] f;
    int n;
    n = 0;
    while (txs(s) !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    repeat (2) @(negedge clk);
    f[0] = txs(s);
    for (int i = 1; i < 10; i++) begin
      repeat (4) @(negedge clk);
      f[i] = txs(s);
    end
    chk(tag, f, {1'b1, e, 1'b0});
  endtask
  task automatic rx_word_a(input logic [31:0] w, input string tag);
    int t;
    rx(1'b0, 8'hA5, {tag, "_hdr"}, t);
    for (int j = 0; j < 4; j++) rx(1'b0, w[8*j +: 8], $sformatf("%s_b%0d", tag, j), t);
  endtask
  task automatic wait_wd(input bit s, input int target, input string tag);
    int n;
    n = 0;
    while ((s ? wdn_b : wdn_a) < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, s ? wdn_b : wdn_a, target);
  endtask
  initial begin
    int t0, t1, t2, t3, t4, t5, n;
    logic [31:0] bw [32];
    // Reset values
    #12;
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_rdreq", rdreq_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_wd", wd_a, 1'b0);
    chk("rst_tx_b", tx_b, 1'b1);
    // Enabled but FIFO empty for 100 cycles
    en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    watch = 1'b1;
    repeat (100) @(negedge clk);
    watch = 1'b0;
    chk("empty_idle", bad_idle, 0);
    chk("empty_reads", pop_a, 0);
    // One word with header
    @(posedge clk);
    #1 mem_a[push_a] = 32'h12345678;
    push_a++;
    rx(1'b0, 8'hA5, "w1_hdr", t0);
    rx(1'b0, 8'h78, "w1_b0", t1);
    rx(1'b0, 8'h56, "w1_b1", t1);
    rx(1'b0, 8'h34, "w1_b2", t1);
    rx(1'b0, 8'h12, "w1_b3", t1);
    wait_wd(1'b0, 1, "w1_done");
    chk("w1_rd_to_tx", t0 - rdc_a, 2);
    chk("w1_length", wdc_a - t0, 200);
    chk("w1_reads", pop_a, 1);
    @(negedge clk);
    chk("w1_busy_after", busy_a, 1'b0);
    chk("w1_wd_once", wdn_a, 1);
    // Two back-to-back words without header
    @(posedge clk);
    #1 mem_b[0] = 32'hDEADBEEF;
    mem_b[1] = 32'h00000001;
    push_b = 2;
    rx(1'b1, 8'hEF, "nh_b0", t0);
    rx(1'b1, 8'hBE, "nh_b1", t1);
    rx(1'b1, 8'hAD, "nh_b2", t2);
    rx(1'b1, 8'hDE, "nh_b3", t3);
    rx(1'b1, 8'h01, "nh_b4", t4);
    rx(1'b1, 8'h00, "nh_b5", t5);
    rx(1'b1, 8'h00, "nh_b6", t5);
    rx(1'b1, 8'h00, "nh_b7", t5);
    wait_wd(1'b1, 2, "nh_done");
    chk("nh_no_gap", t1 - t0, 40);
    chk("nh_word_gap", t4 - t3, 42);
    chk("nh_rd_on_done", co_b, 1);
    chk("nh_reads", pop_b, 2);
    // Enable dropped mid-word
    @(posedge clk);
    #1 mem_a[push_a] = 32'h11223344;
    mem_a[push_a + 1] = 32'h55667788;
    push_a += 2;
    rx(1'b0, 8'hA5, "en_hdr", t0);
    rx(1'b0, 8'h44, "en_b0", t0);
    en = 1'b0;
    rx(1'b0, 8'h33, "en_b1", t0);
    rx(1'b0, 8'h22, "en_b2", t0);
    rx(1'b0, 8'h11, "en_b3", t0);
    wait_wd(1'b0, 2, "en_done");
    repeat (20) @(negedge clk);
    chk("en_held_reads", pop_a, 2);
    chk("en_held_tx", tx_a, 1'b1);
    chk("en_held_busy", busy_a, 1'b0);
    @(posedge clk);
    #1 en = 1'b1;
    rx_word_a(32'h55667788, "en_w2");
    wait_wd(1'b0, 3, "en_w2_done");
    chk("en_reads", pop_a, 3);
    // Reset mid data bit of the first payload byte
    @(posedge clk);
    #1 mem_a[push_a] = 32'hAABBCCDD;
    mem_a[push_a + 1] = 32'h0000F00F;
    push_a += 2;
    rx(1'b0, 8'hA5, "rs_hdr", t0);
    n = 0;
    while (tx_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs_tx", tx_a, 1'b1);
    chk("rs_busy", busy_a, 1'b0);
    chk("rs_rdreq", rdreq_a, 1'b0);
    chk("rs_wd", wd_a, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rx_word_a(32'h0000F00F, "rs_w2");
    wait_wd(1'b0, 4, "rs_done");
    chk("rs_reads", pop_a, 5);
    // Bit-walking words
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      bw[i] = 32'h1 << i;
      mem_a[push_a + i] = bw[i];
    end
    push_a += 32;
    for (int i = 0; i < 32; i++) rx_word_a(bw[i], $sformatf("walk%0d", i));
    wait_wd(1'b0, 36, "walk_done");
    chk("walk_reads", pop_a, 37);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
